// File: rtl/priority_bus_demux_pkg.sv
// priority_bus_pkg: constants and types shared by the priority bus demux and the
// upstream mux. Holds the slot count, the select width, the select encoding and
// the slot state type.
package priority_bus_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SEL_W     = 2;

    // Select encoding, the same as the mux `sel` output.
    localparam logic [SEL_W-1:0] SEL_SLOT0 = 2'd0;
    localparam logic [SEL_W-1:0] SEL_SLOT1 = 2'd1;
    localparam logic [SEL_W-1:0] SEL_SLOT2 = 2'd2;
    localparam logic [SEL_W-1:0] SEL_SLOT3 = 2'd3;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [2:0] popcount4(input logic [NUM_SLOTS-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/priority_bus_demux_if.sv
// priority_bus_demux_if: the source stream and the four per-slot consumer
// channels of the priority bus demux, grouped into one bundle.
//   slave  : the demux side. It receives the source beat and out_ready, and
//            drives in_ready, the slot outputs, drop and drop_cnt.
//   master : the environment side. It drives the source beat and out_ready.
// When PRIORITY_BUS_DEMUX_BROADCAST_EN is defined, the bundle also carries
// in_bcast.
interface priority_bus_demux_if
    import priority_bus_pkg::*;
#(
    parameter int DATA_W = 8
);
`ifdef PRIORITY_BUS_DEMUX_BROADCAST_EN
    logic                 in_bcast;
`endif
    logic                 in_valid;
    logic                 in_ready;
    logic [SEL_W-1:0]     in_sel;
    logic [DATA_W-1:0]    in_data;
    logic [NUM_SLOTS-1:0] out_valid;
    logic [NUM_SLOTS-1:0] out_ready;
    logic [DATA_W-1:0]    out_d0;
    logic [DATA_W-1:0]    out_d1;
    logic [DATA_W-1:0]    out_d2;
    logic [DATA_W-1:0]    out_d3;
    logic [NUM_SLOTS-1:0] drop;
    logic [7:0]           drop_cnt;

    modport slave (
`ifdef PRIORITY_BUS_DEMUX_BROADCAST_EN
        input  in_bcast,
`endif
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_d0, out_d1, out_d2, out_d3, drop, drop_cnt
    );

    modport master (
`ifdef PRIORITY_BUS_DEMUX_BROADCAST_EN
        output in_bcast,
`endif
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_d0, out_d1, out_d2, out_d3, drop, drop_cnt
    );

endinterface

// File: rtl/priority_bus_demux_slot.sv
// demux_slot: one output slot of the demux. It holds one beat in a register,
// runs the EMPTY/FULL state machine and flushes a beat that has waited too long.
//   clk, rst : clock and asynchronous active-high reset
//   load_i   : a beat addressed to this slot is accepted this cycle
//   data_i   : payload of the incoming beat
//   ready_i  : consumer ready for this slot
//   valid_o  : the slot holds a beat
//   data_o   : the held payload; it keeps its value after a drain
//   drop_o   : one-cycle pulse in the cycle after a timeout flush
//
// state      | meaning
// SLOT_EMPTY | no beat held, the slot can accept
// SLOT_FULL  | beat held, waiting for ready_i or for the timeout
module demux_slot
    import priority_bus_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              drop_o
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    slot_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drop_q, flush;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        flush   = 1'b0;
        // If a load and a timeout fall in the same cycle, the load takes
        // precedence: the slot stays full with the new beat and no drop occurs.
        if (load_i) begin
            state_d = SLOT_FULL;
            data_d  = data_i;
            cnt_d   = '0;
        end else if (state_q == SLOT_FULL) begin
            if (ready_i) begin
                state_d = SLOT_EMPTY;
                cnt_d   = '0;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                state_d = SLOT_EMPTY;
                cnt_d   = '0;
                flush   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            drop_q  <= flush;
        end
    end

    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;
    assign drop_o  = drop_q;

endmodule

// File: rtl/priority_bus_demux.sv
// priority_bus_demux: the sink-side demux for the 4-requester priority bus.
// It delivers each tagged source beat into one of four registered slots. Each
// slot has its own valid/ready handshake and a stall timeout.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : priority_bus_demux_if.slave. It carries in_valid/in_ready/
//              in_sel/in_data, out_valid/out_ready, out_d0..3, drop and drop_cnt.
// When PRIORITY_BUS_DEMUX_BROADCAST_EN is defined, bus.in_bcast is added. A
// beat with in_bcast set is written to all four slots, or to none of them.
module priority_bus_demux
    import priority_bus_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    priority_bus_demux_if.slave   bus
);
    logic [NUM_SLOTS-1:0] slot_valid, slot_drop, slot_rdy, load;
    logic [DATA_W-1:0]    slot_data [NUM_SLOTS];
    logic                 accept, bcast;
    logic [7:0]           drop_cnt_q, drop_cnt_d;
    logic [8:0]           drop_sum;

`ifdef PRIORITY_BUS_DEMUX_BROADCAST_EN
    assign bcast = bus.in_bcast;
`else
    assign bcast = 1'b0;
`endif

    // A slot can take a beat when it is empty or when it drains in the same
    // cycle. This path is combinational from out_ready, which allows one beat
    // per cycle per slot.
    assign slot_rdy     = ~slot_valid | bus.out_ready;
    assign bus.in_ready = bcast ? (&slot_rdy) : slot_rdy[bus.in_sel];
    assign accept       = bus.in_valid & bus.in_ready;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        assign load[i] = accept & (bcast | (bus.in_sel == SEL_W'(i)));

        demux_slot #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load_i  (load[i]),
            .data_i  (bus.in_data),
            .ready_i (bus.out_ready[i]),
            .valid_o (slot_valid[i]),
            .data_o  (slot_data[i]),
            .drop_o  (slot_drop[i])
        );
    end

    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + {6'd0, popcount4(slot_drop)};
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt_q <= 8'h00;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign bus.out_valid = slot_valid;
    assign bus.out_d0    = slot_data[0];
    assign bus.out_d1    = slot_data[1];
    assign bus.out_d2    = slot_data[2];
    assign bus.out_d3    = slot_data[3];
    assign bus.drop      = slot_drop;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_priority_bus_demux.sv
// Testbench for priority_bus_demux. A behavioural slot model tracks occupancy
// and the age of each held beat in edges since it was loaded.
module tb_priority_bus_demux;
    localparam int DW = 8;
    localparam int T  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    priority_bus_demux_if #(.DATA_W(DW)) bus ();

    priority_bus_demux #(.DATA_W(DW), .TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model
    logic          m_full [4];
    logic [DW-1:0] m_data [4];
    int            m_load_edge [4];
    int            edge_n;
    logic [3:0]    m_drop;
    int            m_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_full[i] = 1'b0;
            m_data[i] = '0;
            m_load_edge[i] = 0;
        end
        m_drop  = 4'b0000;
        m_total = 0;
        edge_n  = 0;
    endtask

    function automatic logic exp_in_ready(input logic [1:0] s, input logic [3:0] r, input logic b);
        logic all_ok;
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) all_ok = all_ok & (!m_full[i] || r[i]);
        return b ? all_ok : (!m_full[s] || r[s]);
    endfunction

    task automatic check_outputs();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_full[i];
        chk("out_valid", 32'(bus.out_valid), 32'(v));
        chk("out_d0", 32'(bus.out_d0), 32'(m_data[0]));
        chk("out_d1", 32'(bus.out_d1), 32'(m_data[1]));
        chk("out_d2", 32'(bus.out_d2), 32'(m_data[2]));
        chk("out_d3", 32'(bus.out_d3), 32'(m_data[3]));
        chk("drop", 32'(bus.drop), 32'(m_drop));
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_total));
    endtask

    // Drives one cycle of stimulus from the negedge, then checks in_ready,
    // clocks, updates the model and checks the outputs at the next negedge.
    task automatic step(input logic v, input logic [1:0] s, input logic [DW-1:0] d,
                        input logic [3:0] r, input logic b);
        logic       rdy, bc;
        logic [3:0] new_drop;
        int         n;
        bc = 1'b0;
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
`ifdef PRIORITY_BUS_DEMUX_BROADCAST_EN
        bus.in_bcast  = b;
        bc = b;
`endif
        #1;
        rdy = exp_in_ready(s, r, bc);
        chk("in_ready", 32'(bus.in_ready), 32'(rdy));
        @(posedge clk);
        edge_n++;
        new_drop = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (v && rdy && (bc || s == 2'(i))) begin
                m_full[i] = 1'b1;
                m_data[i] = d;
                m_load_edge[i] = edge_n;
            end else if (m_full[i] && r[i]) begin
                m_full[i] = 1'b0;
            end else if (m_full[i] && T != 0 && edge_n - m_load_edge[i] == T) begin
                m_full[i] = 1'b0;
                new_drop[i] = 1'b1;
            end
        end
        n = 0;
        for (int i = 0; i < 4; i++) n += int'(m_drop[i]);
        m_total = (m_total + n > 255) ? 255 : m_total + n;
        m_drop = new_drop;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic [3:0] stall;
        bus.in_valid = 1'b0; bus.in_sel = 2'd0; bus.in_data = '0; bus.out_ready = 4'b0000;
`ifdef PRIORITY_BUS_DEMUX_BROADCAST_EN
        bus.in_bcast = 1'b0;
`endif
        model_reset();
        rst = 1'b1;
        #12;
        check_outputs();
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // unicast to every slot
        step(1, 2'd0, 8'hA1, 4'b1111, 0);
        chk("uni_valid0", 32'(bus.out_valid), 32'h1);
        step(1, 2'd1, 8'hB2, 4'b1111, 0);
        step(1, 2'd2, 8'hC3, 4'b1111, 0);
        step(1, 2'd3, 8'hD4, 4'b1111, 0);
        step(0, 2'd0, 8'h00, 4'b1111, 0);
        chk("uni_d0", 32'(bus.out_d0), 32'hA1);
        chk("uni_d3", 32'(bus.out_d3), 32'hD4);
        chk("uni_cnt", 32'(bus.drop_cnt), 32'd0);

        // backpressure on slot 2
        step(1, 2'd2, 8'hC3, 4'b1011, 0);
        step(1, 2'd2, 8'hEE, 4'b1011, 0);
        chk("bp_held", 32'(bus.out_d2), 32'hC3);
        step(1, 2'd2, 8'hEE, 4'b1111, 0);
        chk("bp_valid2", 32'(bus.out_valid[2]), 32'd1);
        chk("bp_d2", 32'(bus.out_d2), 32'hEE);
        step(0, 2'd0, 8'h00, 4'b1111, 0);

        // independent slots: slot 1 stalled, slot 3 loads
        step(1, 2'd1, 8'hB2, 4'b0000, 0);
        step(1, 2'd3, 8'hE5, 4'b0000, 0);
        chk("ind_d3", 32'(bus.out_d3), 32'hE5);
        chk("ind_d1", 32'(bus.out_d1), 32'hB2);
        step(0, 2'd0, 8'h00, 4'b1111, 0);

        // timeout on slot 3
        step(1, 2'd3, 8'hD4, 4'b0000, 0);
        for (int k = 0; k < T - 1; k++) step(0, 2'd0, 8'h00, 4'b0000, 0);
        step(0, 2'd0, 8'h00, 4'b0000, 0);
        chk("to_drop", 32'(bus.drop), 32'h8);
        chk("to_valid3", 32'(bus.out_valid[3]), 32'd0);
        step(0, 2'd0, 8'h00, 4'b0000, 0);
        chk("to_drop_clr", 32'(bus.drop), 32'h0);
        chk("to_cnt", 32'(bus.drop_cnt), 32'd1);

        // asynchronous reset with slots 0 and 2 full
        step(1, 2'd0, 8'h11, 4'b0000, 0);
        step(1, 2'd2, 8'h22, 4'b0000, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_valid", 32'(bus.out_valid), 32'h0);
        chk("arst_cnt", 32'(bus.drop_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;

        // randomized traffic with slowly changing per-slot stalls
        stall = 4'b0000;
        for (int k = 0; k < 900; k++) begin
            if (k % 40 == 0) stall = 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                 4'($urandom) & ~stall, 0);
        end

`ifdef PRIORITY_BUS_DEMUX_BROADCAST_EN
        step(0, 2'd0, 8'h00, 4'b1111, 0);
        step(1, 2'd1, 8'h33, 4'b0000, 0);
        step(1, 2'd0, 8'h5A, 4'b0000, 1);
        chk("bc_blocked", 32'(bus.out_d0 == 8'h5A), 32'd0);
        step(1, 2'd0, 8'h5A, 4'b0010, 1);
        chk("bc_valid", 32'(bus.out_valid), 32'hF);
        chk("bc_d2", 32'(bus.out_d2), 32'h5A);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/priority_bus_demux.md
# priority_bus_demux

Sink-side counterpart of the 4-requester priority bus multiplexer. It takes one 8-bit source stream tagged with a 2-bit destination select and delivers each beat into one of four registered output slots. Each slot has its own valid/ready handshake. Slots that stall beyond a timeout are flushed and counted. It sits between the muxed shared bus and the four consumers that the encoder's `sel` code addresses.

## Interface
Parameters:
- `DATA_W`, 8: payload width.
- `TIMEOUT`, 16: cycles a full slot may wait for `out_ready` before being dropped. 0 disables timeout.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `in_valid`, input, 1: source beat present.
- `in_ready`, output, 1: beat accepted this cycle when `in_valid & in_ready`.
- `in_sel`, input, 2: destination slot 0..3; same encoding as the mux `sel`.
- `in_data`, input, DATA_W: payload.
- `out_valid`, output, 4: per-slot data valid.
- `out_ready`, input, 4: per-slot consumer ready.
- `out_d0`..`out_d3`, output, DATA_W each: per-slot registered payload.
- `drop`, output, 4: one-cycle pulse when the slot is flushed by timeout.
- `drop_cnt`, output, 8: total drops, saturating at 8'hFF.

## Operation
- Each slot is a one-entry register with a 2-state FSM:
  - EMPTY → FULL on accept addressed to it.
  - FULL → EMPTY on `out_valid & out_ready` with no new accept.
  - FULL → EMPTY on timeout.
  - FULL → FULL on simultaneous drain and accept.
- Ready rule: `in_ready = ~out_valid[in_sel] | out_ready[in_sel]`. This is combinational from `out_ready`, which gives full throughput of one beat per cycle per slot.
- Only the addressed slot changes on accept. All other slots hold their state and data.
- Wait counter per slot:
  - Clears on entering FULL and on every accept into that slot.
  - Increments each FULL cycle with `out_ready` low.
  - When it reaches TIMEOUT-1 with `out_ready` still low: the next edge flushes the slot to EMPTY and pulses `drop[i]`.
- Timeout vs. accept in the same cycle: the accept wins. The slot stays FULL with new data, the counter clears, and no drop is issued.
- `drop_cnt` adds the popcount of `drop` each cycle and saturates.
- `out_dN` holds its last value when the slot is EMPTY. It is not cleared on drain.
- `in_data`/`in_sel` are ignored when `in_valid` is low. `in_ready` is still driven from the current `in_sel`.

## Timing
- Reset values: `out_valid`=0, `out_d0..3`=0, `drop`=0, `drop_cnt`=0, wait counters 0, all slots EMPTY. `in_ready`=1 as a consequence.
- Reset asserted mid-transfer discards all held beats immediately (asynchronous). The first accept is possible in the first cycle after release.
- Latency: a beat accepted at edge N appears on `out_valid`/`out_dN` after edge N. A consumer can take it at edge N+1.
- Minimum occupancy: 1 cycle.
- Timeout: with TIMEOUT=T, a beat never taken is dropped at the T-th edge after it was loaded. `drop` is high for the following cycle only.

## Configuration
- `PRIORITY_BUS_DEMUX_BROADCAST_EN`
  - Defined: adds input `in_bcast` (1 bit).
    - A beat with `in_bcast`=1 is written to all four slots.
    - `in_ready` for a broadcast beat is the AND of the per-slot ready rule across all slots, so a broadcast is all-or-nothing.
    - `in_sel` is ignored for broadcast beats.
  - Undefined: port absent; unicast only.

## Structure
- Package `priority_bus_pkg` holds:
  - slot state enum (`SLOT_EMPTY`, `SLOT_FULL`)
  - `NUM_SLOTS`=4
  - `SEL_W`=2
  - the `sel` encoding constants shared with the mux.
- One sub-module, `demux_slot`, instantiated four times. It contains the slot FSM, data register, wait counter and drop pulse.
- The top level contains: select decode, `in_ready` logic, broadcast gating, and `drop_cnt`.

## Test plan
- Reset then unicast: send sel=0..3 with data A1, B2, C3, D4, `out_ready`=4'b1111 → each `out_valid[i]` pulses one cycle later with `out_dN` = A1/B2/C3/D4; `drop_cnt`=0.
- Backpressure: sel=2 with data C3, `out_ready[2]`=0, then a second beat to sel=2 → `in_ready`=0 and the beat is held. Raise `out_ready[2]` → C3 drains and the new beat loads the same cycle; `out_valid[2]` stays 1.
- Independent slots: slot 1 full and stalled; send E5 to sel=3 → accepted; `out_d3`=E5 while `out_d1` remains B2.
- Timeout: TIMEOUT=16, load D4 into slot 3, `out_ready`=0 → `drop`=4'b1000 for exactly one cycle at edge 16 after load; `drop_cnt`=1; `out_valid[3]`=0.
- Async reset mid-operation: slots 0 and 2 full, assert `rst` between edges → `out_valid`=0 and `drop_cnt`=0 immediately.
- Broadcast (macro defined): `in_bcast`=1, data 5A, slot 1 full and stalled → `in_ready`=0. Release slot 1 → all four slots show 5A on the next cycle.
